// File: rtl/instr_fetch_queue.sv
// Fetch front end: loadable instruction memory, PC/fetch control FSM and an
// in-order instruction queue drained by the issue stage over valid/ready.
module instr_fetch_queue #(
  parameter int INSTR_W  = 12,
  parameter int PC_W     = 4,
  parameter int IQ_DEPTH = 4,
  parameter int CNT_W    = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               imem_we,
  input  logic [PC_W-1:0]    imem_waddr,
  input  logic [INSTR_W-1:0] imem_wdata,
  input  logic               start,
  input  logic [PC_W-1:0]    start_pc,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               iq_valid,
  output logic [INSTR_W-1:0] iq_instr,
  output logic [PC_W-1:0]    iq_pc,
  input  logic               iq_ready,
  output logic [CNT_W-1:0]   iq_count,
  output logic [PC_W-1:0]    pc,
  output logic               busy,
  output logic               done
);

  localparam int PTR_W     = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1;
  localparam int MEM_DEPTH = 1 << PC_W;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(IQ_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PC_W-1:0]  PC_ZERO  = {PC_W{1'b0}};
  localparam logic [PC_W-1:0]  PC_ONE   = PC_W'(1);
  localparam logic [PC_W-1:0]  PC_LAST  = {PC_W{1'b1}};

  logic [INSTR_W-1:0] mem_r     [MEM_DEPTH];
  logic [INSTR_W-1:0] q_instr_r [IQ_DEPTH];
  logic [PC_W-1:0]    q_pc_r    [IQ_DEPTH];

  logic [1:0]       state_r;
  logic [PC_W-1:0]  pc_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             valid_r;
  logic             busy_r;
  logic             done_r;

  logic             flush_s;
  logic             empty_s;
  logic             deq_s;
  logic             space_s;
  logic             enq_s;
  logic [1:0]       state_nxt_s;
  logic [PC_W-1:0]  pc_nxt_s;
  logic [CNT_W-1:0] count_nxt_s;
  logic [INSTR_W-1:0] head_instr_s;
  logic [PC_W-1:0]    head_pc_s;

  // Redirect beats everything; a flushing edge neither enqueues nor dequeues.
  always_comb begin
    flush_s = redirect_valid && (state_r != ST_IDLE);
    empty_s = (count_r == CNT_ZERO);
    deq_s   = !flush_s && !empty_s && iq_ready;
    space_s = (count_r < CNT_FULL) || deq_s;
    enq_s   = !flush_s && (state_r == ST_FETCH) && space_s;
  end

  // Occupancy update; full/empty are decided from this count, not the pointers.
  always_comb begin
    count_nxt_s = count_r;
    if (flush_s) begin
      count_nxt_s = CNT_ZERO;
    end else if (enq_s && !deq_s) begin
      count_nxt_s = count_r + CNT_ONE;
    end else if (deq_s && !enq_s) begin
      count_nxt_s = count_r - CNT_ONE;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Fetch FSM and PC: the last address parks the PC at all-ones instead of wrapping.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    if (flush_s) begin
      state_nxt_s = ST_FETCH;
      pc_nxt_s    = redirect_pc;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_nxt_s = ST_FETCH;
            pc_nxt_s    = start_pc;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_FETCH: begin
          if (enq_s && (pc_r == PC_LAST)) begin
            state_nxt_s = ST_DRAIN;
          end else if (enq_s) begin
            pc_nxt_s = pc_r + PC_ONE;
          end else begin
            pc_nxt_s = pc_r;
          end
        end
        ST_DRAIN: begin
          if (count_nxt_s == CNT_ZERO) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_DRAIN;
          end
        end
        ST_DONE: begin
          if (start) begin
            state_nxt_s = ST_FETCH;
            pc_nxt_s    = start_pc;
          end else begin
            state_nxt_s = ST_DONE;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          pc_nxt_s    = PC_ZERO;
        end
      endcase
    end
  end

  // Control state, pointers and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      pc_r     <= PC_ZERO;
      rd_ptr_r <= PTR_ZERO;
      wr_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
      valid_r  <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
      count_r <= count_nxt_s;
      valid_r <= (count_nxt_s != CNT_ZERO);
      busy_r  <= (state_nxt_s != ST_IDLE);
      done_r  <= (state_nxt_s == ST_DONE);
      if (flush_s) begin
        rd_ptr_r <= PTR_ZERO;
        wr_ptr_r <= PTR_ZERO;
      end else begin
        if (enq_s) begin
          wr_ptr_r <= wr_ptr_r + PTR_ONE;
        end
        if (deq_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_ONE;
        end
      end
    end
  end

  // Queue payload storage; contents are meaningless while count says empty.
  always_ff @(posedge clk) begin
    if (enq_s) begin
      q_instr_r[wr_ptr_r] <= mem_r[pc_r];
      q_pc_r[wr_ptr_r]    <= pc_r;
    end
  end

  // Instruction memory load port, only open while idle.
  always_ff @(posedge clk) begin
    if (imem_we && (state_r == ST_IDLE)) begin
      mem_r[imem_waddr] <= imem_wdata;
    end
  end

  // Head entry is presented with no extra cycle and forced to zero when empty.
  always_comb begin
    if (empty_s) begin
      head_instr_s = {INSTR_W{1'b0}};
      head_pc_s    = PC_ZERO;
    end else begin
      head_instr_s = q_instr_r[rd_ptr_r];
      head_pc_s    = q_pc_r[rd_ptr_r];
    end
  end

  assign iq_valid = valid_r;
  assign iq_instr = head_instr_s;
  assign iq_pc    = head_pc_s;
  assign iq_count = count_r;
  assign pc       = pc_r;
  assign busy     = busy_r;
  assign done     = done_r;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: load, stream, backpressure, pointer
// wrap, redirect, last-address corner, ignored write and async reset.
module tb_instr_fetch_queue;

  logic        clk;
  logic        rst_n;
  logic        imem_we;
  logic [3:0]  imem_waddr;
  logic [11:0] imem_wdata;
  logic        start;
  logic [3:0]  start_pc;
  logic        redirect_valid;
  logic [3:0]  redirect_pc;
  logic        iq_valid;
  logic [11:0] iq_instr;
  logic [3:0]  iq_pc;
  logic        iq_ready;
  logic [2:0]  iq_count;
  logic [3:0]  pc;
  logic        busy;
  logic        done;

  int vec_cnt = 0;
  int err_cnt = 0;
  int exp_pc;

  instr_fetch_queue #(.INSTR_W(12), .PC_W(4), .IQ_DEPTH(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .start(start), .start_pc(start_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .iq_valid(iq_valid), .iq_instr(iq_instr), .iq_pc(iq_pc),
    .iq_ready(iq_ready), .iq_count(iq_count), .pc(pc),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 64 && done !== 1'b1; i++) tick();
    chk(tag, {31'd0, done}, 32'd1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, {31'd0, iq_valid}, 32'd0);
    chk({tag, "_count"}, {29'd0, iq_count}, 32'd0);
    chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
    chk({tag, "_done"},  {31'd0, done}, 32'd0);
    chk({tag, "_pc"},    {28'd0, pc}, 32'd0);
    chk({tag, "_iqpc"},  {28'd0, iq_pc}, 32'd0);
    chk({tag, "_instr"}, {20'd0, iq_instr}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; imem_we = 1'b0; imem_waddr = 4'd0; imem_wdata = 12'd0;
    start = 1'b0; start_pc = 4'd0; redirect_valid = 1'b0; redirect_pc = 4'd0;
    iq_ready = 1'b0;
    tick(); tick();
    chk_reset("reset");
    rst_n = 1'b1;

    // load mem[k] = 0x100 + k while idle
    for (int k = 0; k < 16; k++) begin
      imem_we = 1'b1; imem_waddr = 4'(k); imem_wdata = 12'h100 + 12'(k);
      tick();
    end
    imem_we = 1'b0;

    // stream with iq_ready held high
    start = 1'b1; start_pc = 4'd0; iq_ready = 1'b1;
    tick();
    start = 1'b0;
    chk("start_valid", {31'd0, iq_valid}, 32'd0);
    chk("start_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("first_valid", {31'd0, iq_valid}, 32'd1);
    for (int k = 0; k < 16; k++) begin
      chk("stream_pc", {28'd0, iq_pc}, 32'(k));
      chk("stream_instr", {20'd0, iq_instr}, 32'h100 + 32'(k));
      chk("stream_done", {31'd0, done}, 32'd0);
      tick();
    end
    chk("stream_done_end", {31'd0, done}, 32'd1);
    chk("stream_empty", {31'd0, iq_valid}, 32'd0);
    chk("stream_pc_held", {28'd0, pc}, 32'd15);

    // backpressure: queue fills to 4 with pc parked at 4
    iq_ready = 1'b0; start = 1'b1; start_pc = 4'd0;
    tick();
    start = 1'b0;
    chk("bp_done_clr", {31'd0, done}, 32'd0);
    for (int i = 0; i < 5; i++) tick();
    chk("bp_count", {29'd0, iq_count}, 32'd4);
    chk("bp_pc", {28'd0, pc}, 32'd4);
    chk("bp_head", {28'd0, iq_pc}, 32'd0);
    iq_ready = 1'b1;
    tick();
    iq_ready = 1'b0;
    chk("bp_full_count", {29'd0, iq_count}, 32'd4);
    chk("bp_full_pc", {28'd0, pc}, 32'd5);
    chk("bp_full_head", {28'd0, iq_pc}, 32'd1);

    // wrap: hold 3 cycles, then toggle ready for 12 dequeues
    for (int i = 0; i < 3; i++) tick();
    chk("wrap_hold_count", {29'd0, iq_count}, 32'd4);
    exp_pc = 1;
    for (int i = 0; i < 24; i++) begin
      iq_ready = (i % 2 == 0);
      if (iq_ready) begin
        chk("wrap_pc", {28'd0, iq_pc}, 32'(exp_pc));
        chk("wrap_instr", {20'd0, iq_instr}, 32'h100 + 32'(exp_pc));
      end
      tick();
      if (i % 2 == 0) exp_pc++;
    end
    chk("wrap_count", {29'd0, iq_count}, 32'd3);
    chk("wrap_pc_end", {28'd0, pc}, 32'd15);
    iq_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("wrap_tail_pc", {28'd0, iq_pc}, 32'(exp_pc));
      tick();
      exp_pc++;
    end
    chk("wrap_done", {31'd0, done}, 32'd1);

    // redirect at pc 6 with 3 queued
    iq_ready = 1'b0; start = 1'b1; start_pc = 4'd3;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("redir_pre_count", {29'd0, iq_count}, 32'd3);
    chk("redir_pre_pc", {28'd0, pc}, 32'd6);
    redirect_valid = 1'b1; redirect_pc = 4'd2; iq_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    chk("redir_flush_valid", {31'd0, iq_valid}, 32'd0);
    chk("redir_flush_count", {29'd0, iq_count}, 32'd0);
    chk("redir_pc", {28'd0, pc}, 32'd2);
    tick();
    for (int k = 2; k < 5; k++) begin
      chk("redir_stream", {28'd0, iq_pc}, 32'(k));
      tick();
    end
    wait_done("redir_done");

    // start at the last address: one instruction, then drain
    iq_ready = 1'b0; start = 1'b1; start_pc = 4'd15;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("last_count", {29'd0, iq_count}, 32'd1);
    chk("last_pc", {28'd0, pc}, 32'd15);
    chk("last_head", {20'd0, iq_instr}, 32'h10F);
    chk("last_not_done", {31'd0, done}, 32'd0);
    iq_ready = 1'b1;
    tick();
    chk("last_done", {31'd0, done}, 32'd1);
    chk("last_empty", {31'd0, iq_valid}, 32'd0);

    // a write while fetching must be ignored
    iq_ready = 1'b0; start = 1'b1; start_pc = 4'd0;
    tick();
    start = 1'b0;
    imem_we = 1'b1; imem_waddr = 4'd5; imem_wdata = 12'hABC;
    tick();
    imem_we = 1'b0;
    iq_ready = 1'b1;
    wait_done("we_done");
    iq_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 4'd5;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("we_reread_pc", {28'd0, iq_pc}, 32'd5);
    chk("we_reread_instr", {20'd0, iq_instr}, 32'h105);

    // async reset between edges, then restart
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk_reset("async");
    tick();
    rst_n = 1'b1;
    iq_ready = 1'b1; start = 1'b1; start_pc = 4'd14;
    tick();
    start = 1'b0;
    tick();
    chk("restart_pc14", {20'd0, iq_instr}, 32'h10E);
    tick();
    chk("restart_pc15", {28'd0, iq_pc}, 32'd15);
    tick();
    chk("restart_done", {31'd0, done}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
